// File: rtl/bus_dma_if.sv
// Native valid/ready memory bus between an initiator (master) and a responder (slave).
interface bus_dma_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/bus_dma.sv
// Word-copy DMA initiator: one read then one write per word, with a bus-stall
// timeout that aborts the job and raises a sticky error flag.
module bus_dma #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] count,
  input  logic               src_inc,
  output logic               busy,
  output logic               done,
  output logic               error,
  bus_dma_if.master          mem
);
  localparam int unsigned AW     = 32;
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [AW-1:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [AW-1:0] WORD_STEP = 32'h0000_0004;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      src_q, src_d;
  logic [AW-1:0]      dst_q, dst_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               inc_q, inc_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               valid_q, valid_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [AW-1:0]      wdata_q, wdata_d;
  logic               stall_expired_c;

  // The last permitted stall cycle aborts unless the responder completes in it.
  assign stall_expired_c = (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      inc_q   <= 1'b0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      inc_q   <= inc_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    inc_d   = inc_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          src_d   = src_addr & WORD_MASK;
          dst_d   = dst_addr & WORD_MASK;
          rem_d   = count;
          inc_d   = src_inc;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (count == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
            valid_d = 1'b1;
            addr_d  = src_addr & WORD_MASK;
            wstrb_d = 4'h0;
            wait_d  = '0;
          end
        end
      end
      S_RD: begin
        if (mem.mem_ready) begin
          wdata_d = mem.mem_rdata;
          valid_d = 1'b0;
          state_d = S_RGAP;
        end else if (stall_expired_c) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RGAP: begin
        state_d = S_WR;
        valid_d = 1'b1;
        addr_d  = dst_q;
        wstrb_d = 4'hF;
        wait_d  = '0;
      end
      S_WR: begin
        if (mem.mem_ready) begin
          dst_d   = dst_q + WORD_STEP;
          src_d   = inc_q ? (src_q + WORD_STEP) : src_q;
          rem_d   = rem_q - COUNT_W'(1);
          valid_d = 1'b0;
          state_d = (rem_q == COUNT_W'(1)) ? S_FIN : S_WGAP;
        end else if (stall_expired_c) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WGAP: begin
        state_d = S_RD;
        valid_d = 1'b1;
        addr_d  = src_q;
        wstrb_d = 4'h0;
        wait_d  = '0;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_instr = 1'b0;
  assign mem.mem_wstrb = wstrb_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_addr  = addr_q;
endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: randomized responder and jobs checked every cycle against a
// transaction-level model of the copy schedule, plus literal spot checks.
module tb_bus_dma;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] count;
  logic        src_inc;
  logic        busy;
  logic        done;
  logic        error;

  bus_dma_if bus ();

  bus_dma #(.COUNT_W(16), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .src_inc  (src_inc),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .mem      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the job schedule: expected request, its address/data, busy window, done cycle.
  int          m_busy_start = 0;
  int          m_busy_end   = -1;
  int          m_done_at    = -1;
  int          m_next_req   = -1;
  bit          m_req_on     = 1'b0;
  bit          m_is_wr      = 1'b0;
  bit          m_err        = 1'b0;
  logic [31:0] m_src, m_dst;
  int          m_cnt, m_idx, m_inc, m_wait, m_planned, m_req_in_job;
  logic [31:0] m_data_q[$];

  // Responder configuration and observation logs.
  int          fixed_wait = -1;
  int          stall_req  = -1;
  bit          allow_tmo  = 1'b0;
  bit          prng_mode  = 1'b0;
  logic [31:0] prng_val   = '0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          done_cnt, done_cyc, start_cyc, valid_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input int k);
    int r;
    if (k == stall_req) return 1000;
    if (fixed_wait >= 0) return fixed_wait;
    r = int'($urandom_range(0, 15));
    if (r < 8) return 0;
    if (r < 12) return int'($urandom_range(1, 2));
    if (r < 14) return int'(TMO) - 1;
    return allow_tmo ? 1000 : 0;
  endfunction

  function automatic logic [31:0] exp_addr();
    if (m_is_wr) return m_dst + 32'(m_idx * 4);
    return m_src + 32'(m_idx * 4 * m_inc);
  endfunction

  function automatic bit exp_busy();
    return (cyc >= m_busy_start) && (cyc <= m_busy_end);
  endfunction

  task automatic model_reset();
    m_busy_start = 0;
    m_busy_end   = -1;
    m_done_at    = -1;
    m_next_req   = -1;
    m_req_on     = 1'b0;
    m_is_wr      = 1'b0;
    m_err        = 1'b0;
    m_data_q.delete();
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    valid_seen = 0;
  endtask

  // One clock: check this cycle's outputs, drive responder/start, advance the model.
  task automatic step(input bit st);
    bit          rdy;
    logic [31:0] rd;
    @(negedge clk);
    chk("mem_valid", 32'(bus.mem_valid), 32'(m_req_on));
    if (m_req_on) begin
      chk("mem_addr", bus.mem_addr, exp_addr());
      chk("mem_wstrb", 32'(bus.mem_wstrb), m_is_wr ? 32'hF : 32'h0);
      if (m_is_wr) chk("mem_wdata", bus.mem_wdata, m_data_q[0]);
      chk("mem_instr", 32'(bus.mem_instr), 32'h0);
    end
    chk("busy", 32'(busy), 32'(exp_busy()));
    chk("done", 32'(done), 32'(cyc == m_done_at));
    chk("error", 32'(error), 32'(m_err));
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.mem_valid) valid_seen++;

    rdy = m_req_on ? (m_wait >= m_planned) : ($urandom_range(0, 3) == 0);
    rd  = prng_mode ? prng_val : $urandom;
    bus.mem_ready = rdy;
    bus.mem_rdata = rd;
    start = st;
    if (bus.mem_valid && rdy) begin
      if (bus.mem_wstrb == 4'h0) rd_log.push_back(bus.mem_addr);
      else begin
        wr_addr_log.push_back(bus.mem_addr);
        wr_data_log.push_back(bus.mem_wdata);
      end
    end

    if (m_req_on) begin
      if (rdy) begin
        m_req_on = 1'b0;
        if (!m_is_wr) begin
          m_data_q.push_back(rd);
          if (prng_mode) prng_val = prng_val + 32'd1;
          m_is_wr    = 1'b1;
          m_next_req = cyc + 2;
        end else begin
          void'(m_data_q.pop_front());
          m_idx++;
          m_is_wr = 1'b0;
          if (m_idx == m_cnt) begin
            m_done_at  = cyc + 2;
            m_busy_end = cyc + 2;
          end else begin
            m_next_req = cyc + 2;
          end
        end
      end else begin
        m_wait++;
        if (m_wait == int'(TMO)) begin
          m_req_on   = 1'b0;
          m_err      = 1'b1;
          m_done_at  = cyc + 2;
          m_busy_end = cyc + 2;
        end
      end
    end

    if (st && resetn && !exp_busy()) begin
      m_busy_start = cyc + 1;
      m_err        = 1'b0;
      m_src        = src_addr & 32'hFFFF_FFFC;
      m_dst        = dst_addr & 32'hFFFF_FFFC;
      m_cnt        = int'(count);
      m_inc        = int'(src_inc);
      m_idx        = 0;
      m_is_wr      = 1'b0;
      m_req_in_job = 0;
      m_data_q.delete();
      start_cyc    = cyc;
      if (count == 16'd0) begin
        m_done_at  = cyc + 2;
        m_busy_end = cyc + 2;
      end else begin
        m_busy_end = 32'h7FFF_FFFF;
        m_next_req = cyc + 1;
      end
    end

    if (m_next_req == cyc + 1) begin
      m_req_in_job++;
      m_req_on   = 1'b1;
      m_wait     = 0;
      m_planned  = pick(m_req_in_job);
      m_next_req = -1;
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] n, input logic inc);
    src_addr = s;
    dst_addr = d;
    count    = n;
    src_inc  = inc;
    step(1'b1);
  endtask

  task automatic finish_job();
    int budget;
    budget = 400;
    while (cyc <= m_busy_end && budget > 0) begin
      step(1'b0);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL job_timeout cyc=%0d actual=busy required=idle", cyc);
      model_reset();
    end
    step(1'b0);
  endtask

  initial begin
    resetn        = 1'b0;
    start         = 1'b0;
    src_addr      = '0;
    dst_addr      = '0;
    count         = '0;
    src_inc       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    clear_logs();

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    resetn = 1'b1;
    step(1'b0);

    // Fixed-source drain of a PRNG-like register.
    clear_logs();
    prng_mode  = 1'b1;
    prng_val   = 32'h1111_0001;
    fixed_wait = 0;
    launch(32'h2000_0000, 32'h0000_1000, 16'd3, 1'b0);
    finish_job();
    prng_mode = 1'b0;
    chk("drain_nrd", 32'(rd_log.size()), 32'd3);
    chk("drain_nwr", 32'(wr_addr_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
      chk("drain_rd_addr", rd_log[i], 32'h2000_0000);
      chk("drain_wr_addr", wr_addr_log[i], 32'h0000_1000 + 32'(4 * i));
      chk("drain_wr_data", wr_data_log[i], 32'h1111_0001 + 32'(i));
    end
    chk("drain_done_cnt", 32'(done_cnt), 32'd1);
    chk("drain_busy_after", 32'(busy), 32'h0);

    // Incrementing copy with two wait states per transfer.
    clear_logs();
    fixed_wait = 2;
    launch(32'h0000_0100, 32'h0000_0200, 16'd4, 1'b1);
    finish_job();
    chk("copy_nrd", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
      chk("copy_rd_addr", rd_log[i], 32'h0000_0100 + 32'(4 * i));
      chk("copy_wr_addr", wr_addr_log[i], 32'h0000_0200 + 32'(4 * i));
    end

    // Zero-length job.
    clear_logs();
    fixed_wait = 0;
    launch(32'h0000_0300, 32'h0000_0400, 16'd0, 1'b1);
    finish_job();
    chk("zero_done_delay", 32'(done_cyc - start_cyc), 32'd2);
    chk("zero_valid_seen", 32'(valid_seen), 32'd0);
    chk("zero_error", 32'(error), 32'h0);

    // Timeout on the second read abandons the rest of the job.
    clear_logs();
    stall_req = 3;
    launch(32'h0000_0500, 32'h0000_0600, 16'd3, 1'b1);
    finish_job();
    stall_req = -1;
    chk("tmo_error", 32'(error), 32'h1);
    chk("tmo_nwr", 32'(wr_addr_log.size()), 32'd1);
    chk("tmo_done_cnt", 32'(done_cnt), 32'd1);
    launch(32'h0000_0700, 32'h0000_0800, 16'd1, 1'b1);
    finish_job();
    chk("tmo_error_cleared", 32'(error), 32'h0);

    // A second start during a running job is ignored.
    clear_logs();
    launch(32'h0000_0900, 32'h0000_0A00, 16'd2, 1'b1);
    repeat (2) step(1'b0);
    src_addr = 32'h0000_0F00;
    count    = 16'd5;
    step(1'b1);
    finish_job();
    chk("busy_start_nrd", 32'(rd_log.size()), 32'd2);
    chk("busy_start_nwr", 32'(wr_addr_log.size()), 32'd2);
    chk("busy_start_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset during the second write.
    clear_logs();
    fixed_wait = 1;
    launch(32'h0000_1100, 32'h0000_1200, 16'd8, 1'b1);
    for (int b = 0; b < 100 && !(m_req_on && m_is_wr && m_idx == 1); b++) step(1'b0);
    @(negedge clk);
    chk("rst_mid_valid_before", 32'(bus.mem_valid), 32'h1);
    chk("rst_mid_wstrb_before", 32'(bus.mem_wstrb), 32'hF);
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    model_reset();
    bus.mem_ready = 1'b0;
    done_cnt = 0;
    repeat (2) step(1'b0);
    resetn = 1'b1;
    step(1'b0);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    fixed_wait = -1;
    launch(32'h0000_1300, 32'h0000_1400, 16'd2, 1'b1);
    finish_job();
    chk("rst_mid_rerun_done", 32'(done_cnt), 32'd1);

    // Randomized jobs, including address wrap and timeouts.
    allow_tmo = 1'b1;
    for (int j = 0; j < 25; j++) begin
      logic [31:0] s, d;
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      launch(s, d, 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      finish_job();
      if ($urandom_range(0, 1) == 1) step(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
